// File: rtl/alu_exec_pipe_if.sv
// Handshake bundle between the ALU execution pipe and its neighbours.
// The upstream/downstream side (or a bench) uses master; the pipe uses slave.
interface alu_exec_pipe_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       ALUControl;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;
  logic [CNT_W-1:0] retired_cnt;

  modport master (
    output in_valid, ALUControl, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal, retired_cnt
  );

  modport slave (
    input  in_valid, ALUControl, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero, illegal, retired_cnt
  );
endinterface

// File: rtl/alu_exec_pipe.sv
// Two-stage valid/ready ALU for the RV32I datapath.
// S1 holds the captured operands and code, S2 holds the registered result
// with its zero/illegal flags until downstream takes it. A retired-op counter
// tracks every result handed downstream.
module alu_exec_pipe #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input logic            clk,
  input logic            rst_n,
  alu_exec_pipe_if.slave bus
);

  logic             s1_valid;
  logic [2:0]       s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_result;
  logic             s2_zero;
  logic             s2_illegal;

  logic [CNT_W-1:0] retired;

  logic             s2_adv;
  logic             in_xfer;
  logic             out_xfer;
  logic [WIDTH-1:0] alu_result;
  logic             alu_illegal;

  // S2 can take the S1 op whenever S2 is empty or being drained this cycle,
  // so a full pipe still moves one op per cycle with no bubble.
  assign s2_adv   = s1_valid & (~s2_valid | bus.out_ready);
  assign bus.in_ready = rst_n & (~s1_valid | s2_adv);
  assign in_xfer  = bus.in_valid & bus.in_ready;
  assign out_xfer = s2_valid & bus.out_ready;

  assign bus.out_valid   = s2_valid;
  assign bus.result      = s2_result;
  assign bus.zero        = s2_zero;
  assign bus.illegal     = s2_illegal;
  assign bus.retired_cnt = retired;

  // Combinational ALU on the S1 contents; unsupported codes yield 0 and flag illegal.
  always_comb begin
    alu_result  = '0;
    alu_illegal = 1'b0;
    case (s1_op)
      3'b000:  alu_result = s1_a + s1_b;
      3'b001:  alu_result = s1_a - s1_b;
      3'b010:  alu_result = s1_a & s1_b;
      3'b011:  alu_result = s1_a | s1_b;
      3'b101:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
      default: alu_illegal = 1'b1;
    endcase
  end

  // Pipeline registers and retired counter; reset drops every in-flight op.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_op      <= 3'b000;
      s1_a       <= '0;
      s1_b       <= '0;
      s2_valid   <= 1'b0;
      s2_result  <= '0;
      s2_zero    <= 1'b0;
      s2_illegal <= 1'b0;
      retired    <= '0;
    end else begin
      if (in_xfer) begin
        s1_valid <= 1'b1;
        s1_op    <= bus.ALUControl;
        s1_a     <= bus.src_a;
        s1_b     <= bus.src_b;
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end

      if (s2_adv) begin
        s2_valid   <= 1'b1;
        s2_result  <= alu_result;
        s2_zero    <= (alu_result == '0);
        s2_illegal <= alu_illegal;
      end else if (out_xfer) begin
        s2_valid   <= 1'b0;
        s2_result  <= '0;
        s2_zero    <= 1'b0;
        s2_illegal <= 1'b0;
      end

      if (out_xfer) begin
        retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Directed bench for alu_exec_pipe, built with a 4-bit retired counter so the
// wrap can be reached quickly. Inputs change and outputs are sampled around
// the falling edge, away from the active rising edge.
module tb_alu_exec_pipe;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [CNT_W-1:0] exp_cnt;

  alu_exec_pipe_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  alu_exec_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    exp_cnt = '0;
  endtask

  // Sends one op into an empty pipe and waits (bounded) for its result.
  task automatic issue_single(input logic [2:0] op, input logic [WIDTH-1:0] a,
                              input logic [WIDTH-1:0] b, output logic [WIDTH-1:0] r,
                              output logic z, output logic il, output logic ok);
    bus.in_valid   = 1'b1;
    bus.ALUControl = op;
    bus.src_a      = a;
    bus.src_b      = b;
    bus.out_ready  = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    ok = 1'b0;
    r  = '0;
    z  = 1'b0;
    il = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (bus.out_valid) begin
        r  = bus.result;
        z  = bus.zero;
        il = bus.illegal;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    if (ok) exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic test_reset();
    bus.ALUControl = 3'b000;
    bus.src_a      = '0;
    bus.src_b      = '0;
    apply_reset();
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    total++;
    if (bus.result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=00000000", bus.result); end
    total++;
    if (bus.zero !== 1'b0 || bus.illegal !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b want=00", bus.zero, bus.illegal); end
    total++;
    if (bus.retired_cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", bus.retired_cnt); end
    rst_n = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    @(negedge clk);
  endtask

  task automatic test_add_back_to_back();
    bus.out_ready  = 1'b1;
    bus.in_valid   = 1'b1;
    bus.ALUControl = 3'b000;
    bus.src_a      = 32'h7FFF_FFFF;
    bus.src_b      = 32'h1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL add_in_ready got=%b want=1", bus.in_ready); end
    @(negedge clk);
    bus.src_a = 32'd5;
    bus.src_b = 32'd3;
    #1;
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL add_latency got=%b want=0", bus.out_valid); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'h8000_0000 || bus.zero !== 1'b0)
      begin bad++; $display("FAIL add_overflow got=%b/%h want=1/80000000", bus.out_valid, bus.result); end
    @(negedge clk);
    #1;
    total++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'd8)
      begin bad++; $display("FAIL add_second got=%b/%h want=1/00000008", bus.out_valid, bus.result); end
    @(negedge clk);
    #1;
    exp_cnt = exp_cnt + 4'd2;
    total++;
    if (bus.out_valid !== 1'b0 || bus.retired_cnt !== exp_cnt)
      begin bad++; $display("FAIL add_drain got=%b/%0d want=0/%0d", bus.out_valid, bus.retired_cnt, exp_cnt); end
    @(negedge clk);
  endtask

  task automatic test_sub_zero();
    logic [WIDTH-1:0] r;
    logic z, il, ok;
    issue_single(3'b001, 32'h1234, 32'h1234, r, z, il, ok);
    total++;
    if (!ok || r !== 32'h0 || z !== 1'b1 || il !== 1'b0)
      begin bad++; $display("FAIL sub_equal got=%b/%h/%b/%b want=1/00000000/1/0", ok, r, z, il); end
    issue_single(3'b001, 32'h0, 32'h1, r, z, il, ok);
    total++;
    if (!ok || r !== 32'hFFFF_FFFF || z !== 1'b0)
      begin bad++; $display("FAIL sub_wrap got=%b/%h/%b want=1/ffffffff/0", ok, r, z); end
  endtask

  task automatic test_logic_slt_illegal();
    logic [WIDTH-1:0] r;
    logic z, il, ok;
    issue_single(3'b010, 32'hF0F0_1234, 32'hFF00_FF00, r, z, il, ok);
    total++;
    if (!ok || r !== 32'hF000_1200) begin bad++; $display("FAIL and got=%b/%h want=1/f0001200", ok, r); end
    issue_single(3'b011, 32'hF0F0_0000, 32'h0F00_000C, r, z, il, ok);
    total++;
    if (!ok || r !== 32'hFFF0_000C) begin bad++; $display("FAIL or got=%b/%h want=1/fff0000c", ok, r); end
    issue_single(3'b101, 32'hFFFF_FFFF, 32'h1, r, z, il, ok);
    total++;
    if (!ok || r !== 32'h1 || z !== 1'b0) begin bad++; $display("FAIL slt_neg got=%b/%h want=1/00000001", ok, r); end
    issue_single(3'b101, 32'h1, 32'hFFFF_FFFF, r, z, il, ok);
    total++;
    if (!ok || r !== 32'h0 || z !== 1'b1) begin bad++; $display("FAIL slt_pos got=%b/%h/%b want=1/00000000/1", ok, r, z); end
    issue_single(3'b110, 32'h55, 32'h22, r, z, il, ok);
    total++;
    if (!ok || r !== 32'h0 || il !== 1'b1) begin bad++; $display("FAIL illegal_110 got=%b/%h/%b want=1/00000000/1", ok, r, il); end
    issue_single(3'b100, 32'h7, 32'h9, r, z, il, ok);
    total++;
    if (!ok || r !== 32'h0 || il !== 1'b1) begin bad++; $display("FAIL illegal_100 got=%b/%h/%b want=1/00000000/1", ok, r, il); end
    issue_single(3'b000, 32'h7, 32'h9, r, z, il, ok);
    total++;
    if (!ok || r !== 32'h10 || il !== 1'b0) begin bad++; $display("FAIL illegal_clear got=%b/%h/%b want=1/00000010/0", ok, r, il); end
    total++;
    if (bus.retired_cnt !== exp_cnt) begin bad++; $display("FAIL cnt_after_ops got=%0d want=%0d", bus.retired_cnt, exp_cnt); end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] exp_q [3];
    int idx;
    logic c_sent;
    exp_q[0] = 32'd11;
    exp_q[1] = 32'd15;
    exp_q[2] = 32'h3C;
    apply_reset();
    bus.out_ready  = 1'b0;
    bus.in_valid   = 1'b1;
    bus.ALUControl = 3'b000;
    bus.src_a      = 32'd10;
    bus.src_b      = 32'd1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_accept_a got=%b want=1", bus.in_ready); end
    @(negedge clk);
    bus.ALUControl = 3'b001;
    bus.src_a      = 32'd20;
    bus.src_b      = 32'd5;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_accept_b got=%b want=1", bus.in_ready); end
    @(negedge clk);
    bus.ALUControl = 3'b011;
    bus.src_a      = 32'h30;
    bus.src_b      = 32'h0C;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.result !== 32'd11)
        begin bad++; $display("FAIL bp_hold cycle=%0d got=%b/%b/%h want=0/1/0000000b", c, bus.in_ready, bus.out_valid, bus.result); end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    idx    = 0;
    c_sent = 1'b0;
    for (int c = 0; c < 10 && idx < 3; c++) begin
      bus.in_valid = ~c_sent;
      #1;
      if (bus.in_valid && bus.in_ready) c_sent = 1'b1;
      if (bus.out_valid) begin
        total++;
        if (bus.result !== exp_q[idx])
          begin bad++; $display("FAIL bp_order idx=%0d got=%h want=%h", idx, bus.result, exp_q[idx]); end
        idx++;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    #1;
    total++;
    if (idx !== 3) begin bad++; $display("FAIL bp_count got=%0d want=3", idx); end
    total++;
    if (bus.retired_cnt !== 4'd3 || bus.out_valid !== 1'b0 || bus.zero !== 1'b0 || bus.illegal !== 1'b0)
      begin bad++; $display("FAIL bp_final got=%0d/%b/%b/%b want=3/0/0/0", bus.retired_cnt, bus.out_valid, bus.zero, bus.illegal); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    logic stale;
    bus.out_ready  = 1'b0;
    bus.in_valid   = 1'b1;
    bus.ALUControl = 3'b000;
    bus.src_a      = 32'd1;
    bus.src_b      = 32'd1;
    @(negedge clk);
    bus.src_a = 32'd2;
    bus.src_b = 32'd2;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'd2)
      begin bad++; $display("FAIL rst_mid_setup got=%b/%h want=1/00000002", bus.out_valid, bus.result); end
    rst_n         = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0 || bus.retired_cnt !== 4'd0)
      begin bad++; $display("FAIL rst_mid_clear got=%b/%0d want=0/0", bus.out_valid, bus.retired_cnt); end
    rst_n = 1'b1;
    stale = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      if (bus.out_valid !== 1'b0 || bus.retired_cnt !== 4'd0) stale = 1'b1;
    end
    total++;
    if (stale !== 1'b0) begin bad++; $display("FAIL rst_mid_stale got=%b want=0", stale); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back_wrap();
    int sent;
    int seen;
    logic stall;
    apply_reset();
    bus.out_ready  = 1'b1;
    bus.ALUControl = 3'b000;
    sent  = 0;
    seen  = 0;
    stall = 1'b0;
    for (int c = 0; c < 40 && seen < 17; c++) begin
      bus.in_valid = (sent < 17);
      bus.src_a    = sent;
      bus.src_b    = sent;
      #1;
      if (bus.in_valid) begin
        if (bus.in_ready) sent++;
        else stall = 1'b1;
      end
      if (bus.out_valid) begin
        total++;
        if (bus.result !== 2 * seen)
          begin bad++; $display("FAIL stream_result idx=%0d got=%h want=%h", seen, bus.result, 2 * seen); end
        seen++;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    #1;
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL stream_in_ready got=%b want=0", stall); end
    total++;
    if (seen !== 17) begin bad++; $display("FAIL stream_count got=%0d want=17", seen); end
    total++;
    if (bus.retired_cnt !== 4'd1) begin bad++; $display("FAIL cnt_wrap got=%0d want=1", bus.retired_cnt); end
    @(negedge clk);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    exp_cnt = '0;
    test_reset();
    test_add_back_to_back();
    test_sub_zero();
    test_logic_slt_illegal();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
